// File: rtl/shift_normalizer.sv
// shift_normalizer
//   Iterative normalizer: finds the single-bit shift count a barrel shifter
//   needs to bring the leading (dir=1, MSB side) or trailing (dir=0, LSB side)
//   one of an operand to the edge of the word. It shifts one bit per cycle.
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-low reset
//   start  in   request; accepted in IDLE or DONE
//   in     in   operand [WIDTH-1:0], sampled with start
//   dir    in   1 = normalize left (MSB to 1), 0 = normalize right (LSB to 1)
//   busy   out  high while shifting
//   done   out  one-cycle completion pulse
//   out    out  normalized value [WIDTH-1:0]
//   shamt  out  shifts applied [SW-1:0]
//   zero   out  accepted operand was all zeros
//
// SW must equal log2(WIDTH). A nonzero operand needs at most WIDTH-1 shifts,
// so the count register can never wrap.
module shift_normalizer #(
    parameter int WIDTH = 8,
    parameter int SW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic             dir,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [SW-1:0]    shamt,
    output logic             zero
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic             dir_q;
    logic [WIDTH-1:0] work;
    logic [SW-1:0]    cnt;
    logic             zero_q;
    logic             tbit;
    logic             accept;

    // Bit that must be 1 for the operand to count as normalized.
    assign tbit   = dir_q ? work[WIDTH-1] : work[0];
    assign accept = start && (state == IDLE || state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            dir_q  <= 1'b0;
            work   <= '0;
            cnt    <= '0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        // An all-zero operand has no one to find; finish at
                        // once with out=0 (the latched operand) and shamt=0.
                        work   <= in;
                        dir_q  <= dir;
                        cnt    <= '0;
                        zero_q <= (in == '0);
                        state  <= (in == '0) ? DONE : SHIFT;
                    end else begin
                        // Result registers are left alone so they hold
                        // until the next accepted start.
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    // start is ignored here; the operation runs to completion.
                    if (tbit) begin
                        state <= DONE;
                    end else begin
                        work <= dir_q ? {work[WIDTH-2:0], 1'b0}
                                      : {1'b0, work[WIDTH-1:1]};
                        cnt  <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pure state decodes: no combinational path from any input.
    assign busy  = (state == SHIFT);
    assign done  = (state == DONE);
    assign out   = work;
    assign shamt = cnt;
    assign zero  = zero_q;

endmodule

// File: tb/tb_shift_normalizer.sv
module tb_shift_normalizer;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] o;
        logic [2:0]   s;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] din = '0;
    logic         dir = 1'b0;
    logic         busy, done, zero;
    logic [W-1:0] dout;
    logic [2:0]   shamt;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t e;

    shift_normalizer #(.WIDTH(W), .SW(3)) dut (
        .clk(clk), .rst(rst_n), .start(start), .in(din), .dir(dir),
        .busy(busy), .done(done), .out(dout), .shamt(shamt), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out", dout, e.o);
                check("shamt", shamt, e.s);
                check("zero", zero, e.z);
            end
        end
    end

    // Reference: position of the leading/trailing one.
    task automatic model(input logic [W-1:0] v, input logic d,
                         output logic [W-1:0] o, output int s, output logic z);
        z = (v == '0);
        s = 0;
        o = '0;
        if (!z) begin
            if (d) begin
                for (int i = 0; i < W; i++) if (v[i]) s = W - 1 - i;
                o = v << s;
            end else begin
                for (int i = W - 1; i >= 0; i--) if (v[i]) s = i;
                o = v >> s;
            end
        end
    endtask

    // Drive one op, scramble in/dir after acceptance, check latency, busy
    // length and the single-cycle done pulse.
    task automatic run_op(input logic [W-1:0] v, input logic d,
                          input logic [W-1:0] eo, input int es, input logic ez);
        int n, nb;
        bit seen;
        exp_t x;
        @(negedge clk);
        start = 1'b1; din = v; dir = d;
        x.o = eo; x.s = es[2:0]; x.z = ez;
        sb.push_back(x);
        n = 0; nb = 0; seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start = 1'b0; din = ~v; dir = ~d;
            end
            if (busy) nb++;
            if (done) seen = 1;
        end
        check("timeout", {31'd0, seen}, 1);
        if (seen) begin
            check("latency", n, ez ? 1 : es + 2);
            check("busy_cycles", nb, ez ? 0 : es + 1);
            @(negedge clk);
            check("done_width", {31'd0, done}, 0);
        end else begin
            sb.delete();
        end
    endtask

    initial begin
        logic [W-1:0] rv, mo;
        logic rd, mz;
        int ms, n, dcnt;
        bit seen;
        exp_t x;

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_out", dout, 0);
        check("rst_shamt", shamt, 0);
        check("rst_zero", {31'd0, zero}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        run_op(8'h01, 1'b1, 8'h80, 7, 1'b0);
        run_op(8'h66, 1'b1, 8'hCC, 1, 1'b0);
        run_op(8'hFF, 1'b0, 8'hFF, 0, 1'b0);
        run_op(8'h60, 1'b0, 8'h03, 5, 1'b0);
        run_op(8'h00, 1'b1, 8'h00, 0, 1'b1);
        run_op(8'h00, 1'b0, 8'h00, 0, 1'b1);
        run_op(8'h80, 1'b1, 8'h80, 0, 1'b0);
        run_op(8'h80, 1'b0, 8'h01, 7, 1'b0);
        // Results hold in IDLE.
        repeat (3) @(negedge clk);
        check("hold_out", dout, 8'h01);
        check("hold_shamt", shamt, 7);

        // Start re-pulsed mid-SHIFT is ignored; start in DONE is accepted.
        @(negedge clk);
        start = 1'b1; din = 8'h01; dir = 1'b1;
        x.o = 8'h80; x.s = 3'd7; x.z = 1'b0;
        sb.push_back(x);
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            start = (n == 3);
            if (n == 3) din = 8'h0F;
            if (done) seen = 1;
        end
        check("b2b_timeout1", {31'd0, seen}, 1);
        check("b2b_latency1", n, 9);
        start = 1'b1; din = 8'h40; dir = 1'b1;
        x.o = 8'h80; x.s = 3'd1; x.z = 1'b0;
        sb.push_back(x);
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (done) seen = 1;
        end
        check("b2b_timeout2", {31'd0, seen}, 1);
        check("b2b_latency2", n, 3);
        if (!seen) sb.delete();
        @(negedge clk);

        // Reset between edges in the 3rd SHIFT cycle.
        @(negedge clk);
        start = 1'b1; din = 8'h01; dir = 1'b1;
        x.o = 8'h80; x.s = 3'd7; x.z = 1'b0;
        sb.push_back(x);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_done", {31'd0, done}, 0);
        check("abort_out", dout, 0);
        check("abort_shamt", shamt, 0);
        check("abort_zero", {31'd0, zero}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check("no_done_after_rst", dcnt, 0);
        run_op(8'h10, 1'b1, 8'h80, 3, 1'b0);

        // Random operands against the reference.
        for (int i = 0; i < 24; i++) begin
            rv = 8'($urandom_range(0, 255));
            if (i % 8 == 0) rv = '0;
            rd = 1'($urandom_range(0, 1));
            model(rv, rd, mo, ms, mz);
            run_op(rv, rd, mo, ms, mz);
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
